sync_fifo_prog: RTL and testbench

- Single-clock, parametrised successor to the team's dual-clock FIFO, for blocks that do not need to cross clock domains.
- Adds the following to the basic full/empty FIFO:
  - fill-level count
  - programmable almost-full and almost-empty thresholds
  - sticky overflow and underflow error flags
  - synchronous flush
- Sits between same-clock producer/consumer stages in the datapath. Depth is 2**ASIZE.

---
 rtl/sync_fifo_prog.sv | 86 ++++++++
 tb/tb_sync_fifo_prog.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with fill count, programmable almost-full /
// almost-empty thresholds, sticky overflow/underflow flags and synchronous flush.
// Depth is 2**ASIZE. Define SYNC_FIFO_FWFT_EN for first-word-fall-through read
// data; by default rdata is registered with one cycle of read latency.
module sync_fifo_prog #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned ASIZE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  output logic             wfull,
  output logic             walmost_full,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  input  logic [ASIZE:0]   afull_thresh,
  input  logic [ASIZE:0]   aempty_thresh,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned DEPTH = 1 << ASIZE;
  localparam int unsigned PW    = ASIZE + 1;

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE:0]   wptr;
  logic [ASIZE:0]   rptr;
  logic             wr_ok;
  logic             rd_ok;

  // Flags decode the count register only, so no path from winc/rinc to them.
  assign wfull         = (count == PW'(DEPTH));
  assign rempty        = (count == PW'(0));
  assign walmost_full  = (count >= afull_thresh);
  assign ralmost_empty = (count <= aempty_thresh);

  // Accepted transfers; flush drops any request in its cycle.
  assign wr_ok = winc && !wfull  && !flush;
  assign rd_ok = rinc && !rempty && !flush;

  // Pointers, fill count and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + PW'(1);
      if (rd_ok) rptr <= rptr + PW'(1);
      if (wr_ok && !rd_ok)      count <= count + PW'(1);
      else if (rd_ok && !wr_ok) count <= count - PW'(1);
      if (winc && wfull)  overflow  <= 1'b1;
      if (rinc && rempty) underflow <= 1'b1;
    end
  end

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr[ASIZE-1:0]] <= wdata;
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head entry is always presented; rinc pops it.
  assign rdata = mem[rptr[ASIZE-1:0]];
`else
  // Registered read data, updated only on an accepted read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rdata <= '0;
    else if (rd_ok) rdata <= mem[rptr[ASIZE-1:0]];
  end
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Randomised bench for sync_fifo_prog against a queue-based reference model.
module tb_sync_fifo_prog;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic [7:0] wdata = '0;
  logic       winc = 1'b0;
  logic       rinc = 1'b0;
  logic       wfull, walmost_full, rempty, ralmost_empty, overflow, underflow;
  logic [7:0] rdata;
  logic [4:0] count;
  logic [4:0] afull_thresh  = 5'd14;
  logic [4:0] aempty_thresh = 5'd2;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [7:0] q[$];
  logic       m_ov = 1'b0;
  logic       m_un = 1'b0;
  logic [7:0] m_rdata = 8'h00;

  sync_fifo_prog #(.DSIZE(8), .ASIZE(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wdata(wdata), .winc(winc),
    .wfull(wfull), .walmost_full(walmost_full), .rinc(rinc), .rdata(rdata),
    .rempty(rempty), .ralmost_empty(ralmost_empty), .count(count),
    .afull_thresh(afull_thresh), .aempty_thresh(aempty_thresh),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    check("count", 32'(count), 32'(n));
    check("wfull", 32'(wfull), 32'(n == 16));
    check("rempty", 32'(rempty), 32'(n == 0));
    check("walmost_full", 32'(walmost_full), 32'(n >= int'(afull_thresh)));
    check("ralmost_empty", 32'(ralmost_empty), 32'(n <= int'(aempty_thresh)));
    check("overflow", 32'(overflow), 32'(m_ov));
    check("underflow", 32'(underflow), 32'(m_un));
`ifdef SYNC_FIFO_FWFT_EN
    if (n > 0) check("rdata_head", 32'(rdata), 32'(q[0]));
`else
    check("rdata", 32'(rdata), 32'(m_rdata));
`endif
  endtask

  // Model one clock edge from the pre-edge occupancy.
  task automatic model_step(input logic w, input logic r, input logic f, input logic [7:0] d);
    bit full, empty;
    if (f) begin
      q.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
      return;
    end
    full  = (q.size() == 16);
    empty = (q.size() == 0);
    if (r && !empty) m_rdata = q.pop_front();
    if (w && !full)  q.push_back(d);
    if (w && full)   m_ov = 1'b1;
    if (r && empty)  m_un = 1'b1;
  endtask

  task automatic cycle(input logic w, input logic r, input logic f, input logic [7:0] d);
    winc = w; rinc = r; flush = f; wdata = d;
    @(posedge clk);
    model_step(w, r, f, d);
    #1;
    check_all();
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    q.delete();
    m_ov = 1'b0; m_un = 1'b0; m_rdata = 8'h00;
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // 1: fill with 0x01..0x10
    for (int i = 1; i <= 16; i++) cycle(1'b1, 1'b0, 1'b0, 8'(i));
    // 2: overflow attempt, then drain in order
    cycle(1'b1, 1'b0, 1'b0, 8'hAA);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);

    // 3: random traffic across pointer wrap
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 8'($urandom));
    for (int i = 0; i < 200; i++)
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0), 1'b0, 8'($urandom));
    for (int i = 0; i < 200; i++)
      cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0), 1'b0, 8'($urandom));

    // 4: simultaneous read/write at empty, full and mid-level
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    cycle(1'b1, 1'b1, 1'b0, 8'h33);
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
    cycle(1'b1, 1'b1, 1'b0, 8'h44);
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
    cycle(1'b1, 1'b1, 1'b0, 8'h55);

    // 5: flush at count=9 with both errors set and winc high
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 17; i++) cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 1'b1, 8'h77);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);

    // Reset mid-burst, then behave as empty
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
    async_reset();
    cycle(1'b1, 1'b0, 1'b0, 8'h5A);
    // 6: single word in, pop it (FWFT head check lives in check_all)
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 100; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 31) == 0), 8'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
